// File: rtl/sample_byte_packer.sv
// Serializes SAMPLE_W-bit FIFO samples into an LSB-first byte stream, one byte per clock.
// Optional lost-sample counter is enabled by defining PACKER_LOST_COUNT_EN.
module sample_byte_packer #(
  parameter int SAMPLE_W = 48
) (
  input  logic                clk,
  input  logic                reset,
`ifdef PACKER_LOST_COUNT_EN
  input  logic                count_clr,
  output logic [15:0]         lost_count,
`endif
  input  logic                sample_rdy,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                sample_ack,
  output logic                data_rdy,
  output logic [7:0]          data,
  input  logic                data_ack
);

  localparam int NBYTES = SAMPLE_W / 8;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [NBYTES-1:0][7:0] buf_r;
  logic [IDX_W-1:0]       idx_r;
  logic [IDX_W-1:0]       idx_next_s;
  logic [0:0]             state_r;
  logic                   sample_ack_r;
  logic [7:0]             data_r;
  logic                   capture_s;
  logic                   advance_s;
  logic                   finish_s;

  // Decide whether this edge captures a new sample, steps to the next byte, or ends the burst.
  always_comb begin
    capture_s  = 1'b0;
    advance_s  = 1'b0;
    finish_s   = 1'b0;
    idx_next_s = idx_r + IDX_W'(1);
    case (state_r)
      ST_IDLE: begin
        capture_s = sample_rdy && !sample_ack_r;
      end
      ST_SEND: begin
        if (data_ack) begin
          if (idx_r != LAST_IDX) begin
            advance_s = 1'b1;
          end else if (sample_rdy && !sample_ack_r) begin
            // Reload on the last byte so back-to-back samples have no bubble.
            capture_s = 1'b1;
          end else begin
            finish_s = 1'b1;
          end
        end else begin
          advance_s = 1'b0;
        end
      end
      default: begin
        finish_s = 1'b1;
      end
    endcase
  end

  // Sample buffer, byte index, state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_r        <= {SAMPLE_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      state_r      <= ST_IDLE;
      sample_ack_r <= 1'b0;
      data_r       <= 8'h00;
    end else begin
      sample_ack_r <= capture_s;
      if (capture_s) begin
        buf_r   <= sample;
        idx_r   <= {IDX_W{1'b0}};
        data_r  <= sample[7:0];
        state_r <= ST_SEND;
      end else if (advance_s) begin
        idx_r  <= idx_next_s;
        data_r <= buf_r[idx_next_s];
      end else if (finish_s) begin
        state_r <= ST_IDLE;
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign sample_ack = sample_ack_r;
  assign data_rdy   = (state_r == ST_SEND);
  assign data       = data_r;

`ifdef PACKER_LOST_COUNT_EN
  logic [15:0] lost_count_r;

  // Saturating count of captured samples carrying the lost flag; clear has priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      lost_count_r <= 16'h0000;
    end else if (count_clr) begin
      lost_count_r <= 16'h0000;
    end else if (capture_s && sample[SAMPLE_W-1] && (lost_count_r != 16'hFFFF)) begin
      lost_count_r <= lost_count_r + 16'h0001;
    end else begin
      lost_count_r <= lost_count_r;
    end
  end

  assign lost_count = lost_count_r;
`endif

endmodule

// File: tb/tb_sample_byte_packer.sv
// Directed bench for sample_byte_packer with a small show-ahead FIFO model driven from tasks.
module tb_sample_byte_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_rdy;
  logic [47:0] sample;
  logic        sample_ack;
  logic        data_rdy;
  logic [7:0]  data;
  logic        data_ack;
`ifdef PACKER_LOST_COUNT_EN
  logic        count_clr;
  logic [15:0] lost_count;
`endif

  always #5 clk = ~clk;

  sample_byte_packer #(.SAMPLE_W(48)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef PACKER_LOST_COUNT_EN
    .count_clr  (count_clr),
    .lost_count (lost_count),
`endif
    .sample_rdy (sample_rdy),
    .sample     (sample),
    .sample_ack (sample_ack),
    .data_rdy   (data_rdy),
    .data       (data),
    .data_ack   (data_ack)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [47:0] mem [0:31];
  int          rd;
  int          wr;
  bit          lag;
  bit          lag_en;
  bit          ack_prev;
  int          pulses;
  int          t_used;
  logic [7:0]  got [$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic update_fifo();
    sample_rdy = (rd < wr) || lag;
    sample     = (rd < wr) ? mem[rd] : 48'h0;
  endtask

  task automatic push(input logic [47:0] w);
    mem[wr] = w;
    wr++;
    update_fifo();
  endtask

  // One clock: log the byte accepted at this edge, then model the FIFO pop after a sample_ack cycle.
  task automatic tick();
    if (data_rdy && data_ack && !reset) got.push_back(data);
    @(posedge clk);
    #1;
    if (ack_prev) begin
      if (rd < wr) rd++;
      lag = lag_en;
    end else begin
      lag = 1'b0;
    end
    if (sample_ack) begin
      pulses++;
      check_eq("ack_width", 64'(ack_prev), 64'(0));
      check_eq("ack_byte0", 64'(data), 64'(mem[rd][7:0]));
    end
    ack_prev = sample_ack;
    update_fifo();
  endtask

  task automatic run_until(input int n, input int budget, output int used);
    int t = 0;
    while (got.size() < n && t < budget) begin
      tick();
      t++;
    end
    check_eq("timeout", 64'(got.size()), 64'(n));
    used = t;
  endtask

  task automatic check_bytes(input string tag, input logic [47:0] w, input int base);
    logic [7:0] g;
    for (int i = 0; i < 6; i++) begin
      g = (base + i < got.size()) ? got[base + i] : 8'hxx;
      check_eq(tag, 64'(g), 64'(w[8*i +: 8]));
    end
  endtask

  logic [47:0] words3 [0:2];

  initial begin
    reset = 1'b1; data_ack = 1'b0; sample_rdy = 1'b0; sample = 48'h0;
    rd = 0; wr = 0; lag = 1'b0; lag_en = 1'b0; ack_prev = 1'b0; pulses = 0;
`ifdef PACKER_LOST_COUNT_EN
    count_clr = 1'b0;
`endif
    for (int i = 0; i < 32; i++) mem[i] = 48'h0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_data_rdy", 64'(data_rdy), 64'(0));
    check_eq("rst_sample_ack", 64'(sample_ack), 64'(0));
    check_eq("rst_data", 64'(data), 64'(8'h00));
    reset = 1'b0;
    tick();

    // data_ack while idle is ignored
    data_ack = 1'b1;
    repeat (3) tick();
    check_eq("idle_rdy", 64'(data_rdy), 64'(0));
    check_eq("idle_bytes", 64'(got.size()), 64'(0));

    // Single sample with capture latency
    got.delete(); pulses = 0;
    push(48'h8011_2233_4455);
    check_eq("lat_c_rdy", 64'(data_rdy), 64'(0));
    tick();
    check_eq("lat_c1_rdy", 64'(data_rdy), 64'(1));
    check_eq("lat_c1_ack", 64'(sample_ack), 64'(1));
    check_eq("lat_c1_data", 64'(data), 64'(8'h55));
    run_until(6, 20, t_used);
    check_bytes("single", 48'h8011_2233_4455, 0);
    check_eq("single_rdy_after", 64'(data_rdy), 64'(0));
    check_eq("single_pulses", 64'(pulses), 64'(1));

    // Three words back to back: 18 bytes in 18 consecutive cycles
    got.delete(); pulses = 0;
    words3[0] = 48'h0102_0304_0506;
    words3[1] = 48'hF0E0_D0C0_B0A0;
    words3[2] = 48'h7766_5544_3322;
    for (int j = 0; j < 3; j++) push(words3[j]);
    run_until(18, 40, t_used);
    check_eq("b2b_cycles", 64'(t_used), 64'(19));
    for (int j = 0; j < 3; j++) check_bytes("b2b", words3[j], 6 * j);
    check_eq("b2b_pulses", 64'(pulses), 64'(3));
    check_eq("b2b_rdy_after", 64'(data_rdy), 64'(0));

    // Stall five cycles on byte 2
    got.delete();
    push(48'hA6A5_A4A3_A2A1);
    run_until(2, 20, t_used);
    data_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("stall_data", 64'(data), 64'(8'hA3));
      check_eq("stall_rdy", 64'(data_rdy), 64'(1));
    end
    data_ack = 1'b1;
    run_until(6, 20, t_used);
    repeat (2) tick();
    check_eq("stall_count", 64'(got.size()), 64'(6));
    check_bytes("stall_seq", 48'hA6A5_A4A3_A2A1, 0);

    // Reset in the middle of a sample
    got.delete();
    push(48'h6655_4433_2211);
    run_until(4, 20, t_used);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_eq("mid_rst_rdy", 64'(data_rdy), 64'(0));
      check_eq("mid_rst_data", 64'(data), 64'(8'h00));
    end
    reset = 1'b0;
    got.delete();
    push(48'h0000_0000_00AA);
    run_until(1, 20, t_used);
    check_eq("post_rst_first", 64'((got.size() > 0) ? got[0] : 8'hxx), 64'(8'hAA));
    run_until(6, 20, t_used);
    check_bytes("post_rst", 48'h0000_0000_00AA, 0);

`ifdef PACKER_LOST_COUNT_EN
    // Lost-flag counter
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    check_eq("lost_clr", 64'(lost_count), 64'(0));
    got.delete();
    push(48'h8000_0000_0001);
    push(48'h0000_0000_0002);
    push(48'h8000_0000_0003);
    push(48'h8123_4567_89AB);
    push(48'h7FFF_FFFF_FFFF);
    push(48'hFFFF_FFFF_FFFF);
    run_until(36, 60, t_used);
    check_eq("lost_count4", 64'(lost_count), 64'(4));
    got.delete();
    push(48'h8000_0000_0010);
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    check_eq("lost_clr_wins", 64'(lost_count), 64'(0));
    run_until(6, 20, t_used);
    check_eq("lost_after", 64'(lost_count), 64'(0));
`endif

    // sample_rdy lagging high one cycle after each pop
    lag_en = 1'b1;
    got.delete(); pulses = 0;
    push(48'h1111_2222_3333);
    push(48'h4444_5555_6666);
    run_until(12, 40, t_used);
    repeat (4) tick();
    check_eq("lag_pulses", 64'(pulses), 64'(2));
    check_eq("lag_bytes", 64'(got.size()), 64'(12));
    check_eq("lag_rdy_after", 64'(data_rdy), 64'(0));
    check_bytes("lag_w0", 48'h1111_2222_3333, 0);
    check_bytes("lag_w1", 48'h4444_5555_6666, 6);
    lag_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
